// File: rtl/mux_rr_scheduler_if.sv
// Bundle between the round-robin mux scheduler, its requesters, the shared
// 32:1 mux and the downstream valid/ready consumer.
interface mux_rr_scheduler_if #(
  parameter int NUM_REQ = 32,
  parameter int SEL_W   = 5,
  parameter int DATA_W  = 2
);
  logic [NUM_REQ-1:0] req;
  logic [DATA_W-1:0]  mux_out;
  logic [SEL_W-1:0]   sel;
  logic [DATA_W-1:0]  out_data;
  logic               out_valid;
  logic               out_ready;
  logic [NUM_REQ-1:0] gnt;
  logic               busy;

  modport master (
    input  req, mux_out, out_ready,
    output sel, out_data, out_valid, gnt, busy
  );

  modport slave (
    output req, mux_out, out_ready,
    input  sel, out_data, out_valid, gnt, busy
  );
endinterface

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler sharing one 32:1 x 2-bit mux among 32 requesters:
// picks a winner, steers the mux, registers its output and grants on accept.
module mux_rr_scheduler (
  input  logic               clk,
  input  logic               rst,
  mux_rr_scheduler_if.master bus
);
  localparam int NUM_REQ = 32;
  localparam int SEL_W   = 5;
  localparam int DATA_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [SEL_W-1:0]   sel_r, sel_nxt_s;
  logic [SEL_W-1:0]   last_r, last_nxt_s;
  logic [SEL_W-1:0]   winner_s, idx_s;
  logic               found_s;
  logic [DATA_W-1:0]  out_data_r, out_data_nxt_s;
  logic               out_valid_r, out_valid_nxt_s;
  logic [NUM_REQ-1:0] gnt_r, gnt_nxt_s;
  logic               busy_r;

  // Rotating priority search: starts just after the last served index, so
  // the served index itself (offset NUM_REQ, wrapping onto last_r) comes last.
  always_comb begin
    winner_s = {SEL_W{1'b0}};
    found_s  = 1'b0;
    idx_s    = {SEL_W{1'b0}};
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx_s = last_r + SEL_W'(i);
      if (!found_s && bus.req[idx_s]) begin
        winner_s = idx_s;
        found_s  = 1'b1;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Next-state and next-output logic for the IDLE -> ARB -> HOLD cycle.
  always_comb begin
    state_nxt_s     = state_r;
    sel_nxt_s       = sel_r;
    last_nxt_s      = last_r;
    out_data_nxt_s  = out_data_r;
    out_valid_nxt_s = out_valid_r;
    gnt_nxt_s       = {NUM_REQ{1'b0}};
    case (state_r)
      IDLE: begin
        if (|bus.req) begin
          sel_nxt_s   = winner_s;
          state_nxt_s = ARB;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ARB: begin
        out_data_nxt_s  = bus.mux_out;
        out_valid_nxt_s = 1'b1;
        state_nxt_s     = HOLD;
      end
      HOLD: begin
        // The winner is locked here; req changes are ignored until the grant.
        if (out_valid_r && bus.out_ready) begin
          gnt_nxt_s       = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_r;
          last_nxt_s      = sel_r;
          out_valid_nxt_s = 1'b0;
          state_nxt_s     = IDLE;
        end else begin
          state_nxt_s     = HOLD;
        end
      end
      default: begin
        state_nxt_s     = IDLE;
        out_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      sel_r       <= {SEL_W{1'b0}};
      last_r      <= {SEL_W{1'b1}};
      out_data_r  <= {DATA_W{1'b0}};
      out_valid_r <= 1'b0;
      gnt_r       <= {NUM_REQ{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      sel_r       <= sel_nxt_s;
      last_r      <= last_nxt_s;
      out_data_r  <= out_data_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      gnt_r       <= gnt_nxt_s;
      busy_r      <= (state_nxt_s != IDLE);
    end
  end

  assign bus.sel       = sel_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign bus.gnt       = gnt_r;
  assign bus.busy      = busy_r;
endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Bench for mux_rr_scheduler: directed scenarios with literal expectations
// plus randomized traffic, all compared every cycle against a transfer model.
module tb_mux_rr_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] inp [32];
  int checks = 0;
  int failures = 0;

  mux_rr_scheduler_if #(.NUM_REQ(32), .SEL_W(5), .DATA_W(2)) bus ();

  mux_rr_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // The shared 32:1 mux modelled as a combinational lookup.
  assign bus.mux_out = inp[bus.sel];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin pick: first requester strictly after 'last', modulo 32.
  function automatic logic [4:0] rr_pick(input logic [31:0] r, input logic [4:0] last);
    int idx;
    for (int k = 1; k <= 32; k++) begin
      idx = (int'(last) + k) % 32;
      if (r[idx]) return 5'(idx);
    end
    return 5'd0;
  endfunction

  function automatic int onehot_idx(input logic [31:0] g);
    for (int k = 0; k < 32; k++) if (g[k]) return k;
    return -1;
  endfunction

  // Transfer-level model: phase 0 waiting for a request, 1 winner chosen,
  // 2 word offered downstream.
  int         m_phase = 0;
  logic [4:0] m_sel = 5'd0;
  logic [4:0] m_last = 5'd31;
  logic [1:0] m_data = 2'd0;
  logic       m_valid = 1'b0;
  logic [31:0] m_gnt = 32'd0;
  logic       started = 1'b0;

  always @(posedge clk) begin
    started <= 1'b1;
    if (rst) begin
      m_phase <= 0; m_sel <= 5'd0; m_last <= 5'd31;
      m_data <= 2'd0; m_valid <= 1'b0; m_gnt <= 32'd0;
    end else begin
      m_gnt <= 32'd0;
      if (m_phase == 0) begin
        if (bus.req != 32'd0) begin
          m_sel <= rr_pick(bus.req, m_last);
          m_phase <= 1;
        end
      end else if (m_phase == 1) begin
        m_data <= inp[m_sel];
        m_valid <= 1'b1;
        m_phase <= 2;
      end else if (bus.out_ready) begin
        m_gnt <= 32'd1 << m_sel;
        m_last <= m_sel;
        m_valid <= 1'b0;
        m_phase <= 0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("m_sel", 32'(bus.sel), 32'(m_sel));
      chk("m_out_valid", 32'(bus.out_valid), 32'(m_valid));
      if (m_valid) chk("m_out_data", 32'(bus.out_data), 32'(m_data));
      chk("m_gnt", bus.gnt, m_gnt);
      chk("m_busy", 32'(bus.busy), 32'(m_phase != 0));
    end
  end

  task automatic wait_gnt(input int budget, output int idx);
    idx = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (bus.gnt != 32'd0) begin
        idx = onehot_idx(bus.gnt);
        return;
      end
    end
    chk("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (bus.out_valid) return;
    end
    chk("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    bus.req = 32'd0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 32; i++) inp[i] = 2'($urandom);

    // Reset held two cycles with every requester active.
    bus.req = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    chk("rst_sel", 32'(bus.sel), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_gnt", bus.gnt, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    wait_gnt(20, idx);
    chk("first_grant", 32'(idx), 32'd0);
    bus.req = 32'd0;

    // Single requester 5 with cycle-exact latency.
    do_reset();
    inp[5] = 2'b10;
    bus.req = 32'h0000_0020;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("single_sel", 32'(bus.sel), 32'd5);
    chk("single_valid_early", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("single_valid", 32'(bus.out_valid), 32'd1);
    chk("single_data", 32'(bus.out_data), 32'd2);
    chk("single_gnt_early", bus.gnt, 32'd0);
    @(negedge clk);
    chk("single_gnt", bus.gnt, 32'h0000_0020);
    chk("single_valid_drop", 32'(bus.out_valid), 32'd0);
    bus.req = 32'd0;
    @(negedge clk);
    chk("single_gnt_pulse", bus.gnt, 32'd0);
    chk("single_idle", 32'(bus.busy), 32'd0);

    // Round robin over all 32 for three rounds.
    do_reset();
    bus.req = 32'hFFFF_FFFF;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 96; n++) begin
      wait_gnt(10, idx);
      chk("rr_order", 32'(idx), 32'(n % 32));
    end

    // Wrap: after 31 was served, 0 beats 30.
    bus.req = 32'h4000_0001;
    wait_gnt(10, idx);
    chk("wrap_first", 32'(idx), 32'd0);
    bus.req[0] = 1'b0;
    wait_gnt(10, idx);
    chk("wrap_second", 32'(idx), 32'd30);
    bus.req = 32'd0;

    // Backpressure on requester 12.
    do_reset();
    inp[12] = 2'b01;
    bus.out_ready = 1'b0;
    bus.req = 32'h0000_1000;
    wait_valid(10);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_sel", 32'(bus.sel), 32'd12);
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_data", 32'(bus.out_data), 32'd1);
      chk("bp_gnt", bus.gnt, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_gnt_pulse", bus.gnt, 32'h0000_1000);
    chk("bp_idle", 32'(bus.busy), 32'd0);
    bus.req = 32'd0;
    bus.out_ready = 1'b0;

    // Reset while holding a word; pointer must restart from 0 (not after 12).
    @(negedge clk);
    bus.req = 32'h0000_0080;
    wait_valid(10);
    rst = 1'b1;
    @(negedge clk);
    chk("rsthold_valid", 32'(bus.out_valid), 32'd0);
    chk("rsthold_gnt", bus.gnt, 32'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    bus.req = 32'h0010_0008;
    wait_gnt(10, idx);
    chk("rsthold_next", 32'(idx), 32'd3);
    bus.req = 32'd0;

    // Randomized traffic, backpressure, early req drops and occasional reset.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 32; i++) begin
        inp[i] = 2'($urandom);
        if (bus.gnt[i]) bus.req[i] = 1'b0;
        else if (!bus.req[i] && $urandom_range(0, 15) == 0) bus.req[i] = 1'b1;
        else if (bus.req[i] && $urandom_range(0, 255) == 0) bus.req[i] = 1'b0;
      end
    end
    @(negedge clk);
    rst = 1'b0;
    bus.req = 32'd0;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
